// File: rtl/tff_counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tff_counter_ctrl_pkg
// Shared definitions for the TFF counter sequencer: the FSM state encoding and
// the encodings of the latched direction and mode controls.
// -----------------------------------------------------------------------------
package tff_counter_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } state_e;

   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;
   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_FREERUN = 1'b1;

endpackage

// File: rtl/tff_counter_ctrl_if.sv
// -----------------------------------------------------------------------------
// tff_counter_ctrl_if
// Control/observation bundle between the lab top level (master) and the
// counter sequencer (slave).
//   start, stop      run request / abort
//   dir, mode, limit run configuration, captured on an accepted start
//   busy, done       status (busy in LOAD/RUN, done one-cycle pulse)
//   count, t_vec     TFF bank outputs and the toggle vector applied this cycle
// -----------------------------------------------------------------------------
interface tff_counter_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic             dir;
   logic             mode;
   logic [WIDTH-1:0] limit;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] t_vec;

   modport master (
      output start, stop, dir, mode, limit,
      input  busy, done, count, t_vec
   );

   modport slave (
      input  start, stop, dir, mode, limit,
      output busy, done, count, t_vec
   );
endinterface

// File: rtl/tff_cell.sv
// -----------------------------------------------------------------------------
// tff_cell
// Single toggle flip-flop: q inverts on a rising clock edge whenever t is high.
//   clk  rising-edge clock
//   rst  synchronous active-high reset, clears q
//   t    toggle enable
//   q    stored bit
// -----------------------------------------------------------------------------
module tff_cell (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q ^ t;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tff_counter_ctrl
// Sequencer for a bank of WIDTH toggle flip-flops used as a programmable
// synchronous counter. Every change of the count happens through the toggle
// vector: LOAD presets the bank by toggling the bits that differ from the start
// value, RUN produces ripple-style up/down toggle patterns, and a terminal count
// either finishes the run (one-shot) or reloads the start value (free-run).
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   bus    slave side of tff_counter_ctrl_if:
//          start/stop/dir/mode/limit in, busy/done/count/t_vec out
// -----------------------------------------------------------------------------
module tff_counter_ctrl
   import tff_counter_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   tff_counter_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_LOAD = LOAD;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]       state_q, state_d;
   logic             dir_q,   dir_d;
   logic             mode_q,  mode_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             done_q,  done_d;

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] step_vec;
   logic             at_term;

   // Up counting starts at 0 and ends at limit; down counting is the mirror.
   assign start_val = (dir_q == DIR_DOWN) ? limit_q : '0;
   assign term_val  = (dir_q == DIR_DOWN) ? '0 : limit_q;
   assign at_term   = (count == term_val);

   // Counting toggle pattern: a bit toggles when every lower bit is 1 (up)
   // or every lower bit is 0 (down). Bit 0 always toggles.
   always_comb begin
      step_vec    = '0;
      step_vec[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         step_vec[i] = step_vec[i-1] &
                       ((dir_q == DIR_DOWN) ? ~count[i-1] : count[i-1]);
      end
   end

   // Next-state, configuration capture and toggle vector. stop outranks the
   // terminal test, which outranks normal counting.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      limit_d = limit_q;
      done_d  = 1'b0;
      t_vec   = '0;

      case (state_q)
         S_IDLE: begin
            // start wins even when stop is also high here
            if (bus.start) begin
               dir_d   = bus.dir;
               mode_d  = bus.mode;
               limit_d = bus.limit;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            if (bus.stop) begin
               state_d = S_IDLE;
            end else begin
               t_vec   = count ^ start_val;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            if (bus.stop) begin
               state_d = S_IDLE;
            end else if (at_term) begin
               done_d = 1'b1;
               if (mode_q == MODE_ONESHOT) begin
                  state_d = S_DONE;
               end else begin
                  // reload; zero when the span is empty, giving done every cycle
                  t_vec = count ^ start_val;
               end
            end else begin
               t_vec = step_vec;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         dir_q   <= 1'b0;
         mode_q  <= 1'b0;
         limit_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         limit_q <= limit_d;
         done_q  <= done_d;
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
      tff_cell u_cell (
         .clk (clk),
         .rst (rst),
         .t   (t_vec[gi]),
         .q   (count[gi])
      );
   end

   assign bus.busy  = (state_q == S_LOAD) || (state_q == S_RUN);
   assign bus.done  = done_q;
   assign bus.count = count;
   assign bus.t_vec = t_vec;

endmodule
